mem_stream_reader: RTL

Sequencer that drains a strided vector out of a `Memory` instance (registered read address, one-cycle read latency) and presents it as a valid/ready stream. It sits directly downstream of the weight/activation memories and feeds the MAC datapath. It owns the memory's `read_addr`, tracks the in-flight read, and absorbs downstream backpressure in a 2-entry buffer so no read data is ever lost.

---
 rtl/nn_mem_pkg.sv | 18 +
 rtl/mem_stream_reader_if.sv | 34 +++
 rtl/mem_stream_reader_skid_fifo.sv | 57 +++++
 rtl/mem_stream_reader.sv | 113 +++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_mem_pkg
// Description : Shared types and constants for the memory stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader_if
// Description : Command, memory read port and output stream of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stream_reader_if #(
    parameter int DEPTH    = 8,
    parameter int BIT_SIZE = 16
);
    logic                start;
    logic [DEPTH-1:0]    base_addr;
    logic [DEPTH-1:0]    stride;
    logic [DEPTH:0]      length;
    logic                busy;
    logic                done;
    logic [DEPTH-1:0]    read_addr;
    logic [BIT_SIZE-1:0] mem_data;
    logic                out_valid;
    logic                out_ready;
    logic [BIT_SIZE-1:0] out_data;
    logic                out_last;

    modport master (
        input  start, base_addr, stride, length, mem_data, out_ready,
        output busy, done, read_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, stride, length, mem_data, out_ready,
        input  busy, done, read_addr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/mem_stream_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_fifo
// Description : Two-entry register FIFO; the head register drives the output.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= push_data;
                    else                 r_tail <= push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains
                    if (r_count == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = r_count;
    assign head_valid = (r_count != 2'd0);
    assign head       = r_head;
endmodule
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader
// Description : Drains a strided vector from a 1-cycle-latency memory into a
//               valid/ready stream with a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader
    import nn_mem_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BIT_SIZE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_stream_reader_if.master bus
);
    localparam logic [1:0]   c_IDLE  = IDLE;
    localparam logic [1:0]   c_RUN   = RUN;
    localparam logic [1:0]   c_DRAIN = DRAIN;
    localparam logic [DEPTH:0] c_ONE = {{DEPTH{1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [DEPTH-1:0]    r_addr;
    logic [DEPTH-1:0]    r_stride;
    logic [DEPTH:0]      r_remaining;
    logic [DEPTH-1:0]    r_hold_addr;
    logic                r_inflight;
    logic                r_inflight_last;
    logic                r_done;

    logic [1:0]          w_fifo_count;
    logic                w_head_valid;
    logic [BIT_SIZE:0]   w_head;
    logic                w_pop;
    logic                w_issue;
    logic [2:0]          w_occupancy;

    assign w_pop = w_head_valid & bus.out_ready;

    // Entries held plus the one in flight, net of this cycle's pop, must leave room
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == c_RUN) && (w_occupancy < 3'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_addr          <= '0;
            r_stride        <= '0;
            r_remaining     <= '0;
            r_hold_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_hold_addr     <= r_addr;
                r_addr          <= r_addr + r_stride;
                r_remaining     <= r_remaining - c_ONE;
                r_inflight_last <= (r_remaining == c_ONE);
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            r_state     <= c_RUN;
                            r_addr      <= bus.base_addr;
                            r_stride    <= bus.stride;
                            r_remaining <= bus.length;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_issue && (r_remaining == c_ONE)) r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (w_pop && w_head[BIT_SIZE]) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    stream_skid_fifo #(
        .WIDTH (BIT_SIZE + 1)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (r_inflight),
        .push_data  ({r_inflight_last, bus.mem_data}),
        .pop        (w_pop),
        .count      (w_fifo_count),
        .head_valid (w_head_valid),
        .head       (w_head)
    );

    // Between reads the address is held so the memory sees a stable value
    assign bus.read_addr = w_issue ? r_addr : r_hold_addr;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.done      = r_done;
    assign bus.out_valid = w_head_valid;
    assign bus.out_data  = w_head[BIT_SIZE-1:0];
    assign bus.out_last  = w_head_valid & w_head[BIT_SIZE];
endmodule
`default_nettype wire
